taglist_seq_player: RTL and testbench

- Downstream consumer of the taglist RAM.
- Given a requested sequence number, fetches that sequence's 32-bit taglist entry, checks it, then streams every ROM address from the entry's first address to its last address inclusive.
- Addresses are delivered to the playback stage through a valid/ready handshake.
- Sits between the taglist RAM read port and the ROM address input of the playback path.

---
 rtl/taglist_seq_player.sv | 159 +++++++++++++++
 tb/tb_taglist_seq_player.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/taglist_seq_player.sv
// Taglist sequence player: looks up one taglist entry, validates it and
// streams its inclusive ROM address range over a valid/ready handshake.
module taglist_seq_player #(
    parameter int SEQ_W  = 7,
    parameter int ROM_AW = 10,
    parameter int ENT_W  = 32
) (
    input  logic              clk_1KHz,
    input  logic              reset,
    input  logic              start,
    input  logic [SEQ_W-1:0]  seq_req,
    input  logic              abort,
    output logic [SEQ_W-1:0]  ram_addr,
    input  logic [ENT_W-1:0]  ram_rdata,
    output logic [ROM_AW-1:0] rom_addr,
    output logic              addr_valid,
    input  logic              addr_ready,
    output logic              addr_last,
    output logic              rom_end,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int LAST_LSB  = 1;
    localparam int FIRST_LSB = LAST_LSB + ROM_AW;
    localparam int SEQ_LSB   = FIRST_LSB + ROM_AW;
    localparam int TAG_LSB   = SEQ_LSB + SEQ_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_CHECK,
        S_STREAM,
        S_FINISH
    } state_t;

    state_t            state_q, state_d;
    logic [SEQ_W-1:0]  ram_addr_q, ram_addr_d;
    logic [SEQ_W-1:0]  seq_q, seq_d;
    logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;
    logic [ROM_AW-1:0] last_q, last_d;
    logic              valid_q, valid_d;
    logic              alast_q, alast_d;
    logic              rom_end_q, rom_end_d;
    logic              err_q, err_d;

    logic [ENT_W-TAG_LSB-1:0] ent_tag;
    logic [SEQ_W-1:0]         ent_seq;
    logic [ROM_AW-1:0]        ent_first;
    logic [ROM_AW-1:0]        ent_last;
    logic                     ent_ok;
    logic [ROM_AW-1:0]        rom_addr_inc;

    assign ent_tag   = ram_rdata[ENT_W-1:TAG_LSB];
    assign ent_seq   = ram_rdata[TAG_LSB-1:SEQ_LSB];
    assign ent_first = ram_rdata[SEQ_LSB-1:FIRST_LSB];
    assign ent_last  = ram_rdata[FIRST_LSB-1:LAST_LSB];
    assign ent_ok    = (ent_tag == '0) && (ent_seq == seq_q) &&
                       (ent_first <= ent_last);

    assign rom_addr_inc = rom_addr_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        ram_addr_d = ram_addr_q;
        seq_d      = seq_q;
        rom_addr_d = rom_addr_q;
        last_d     = last_q;
        valid_d    = valid_q;
        alast_d    = alast_q;
        rom_end_d  = rom_end_q;
        err_d      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    ram_addr_d = seq_req;
                    seq_d      = seq_req;
                    rom_end_d  = 1'b0;
                    state_d    = S_LOOKUP;
                end
            end
            S_LOOKUP: state_d = S_CHECK;
            S_CHECK: begin
                if (ent_ok) begin
                    rom_addr_d = ent_first;
                    last_d     = ent_last;
                    rom_end_d  = ram_rdata[0];
                    valid_d    = 1'b1;
                    alast_d    = (ent_first == ent_last);
                    state_d    = S_STREAM;
                end else begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_STREAM: begin
                if (valid_q && addr_ready) begin
                    if (rom_addr_q != last_q) begin
                        rom_addr_d = rom_addr_inc;
                        alast_d    = (rom_addr_inc == last_q);
                    end else begin
                        valid_d = 1'b0;
                        alast_d = 1'b0;
                        state_d = S_FINISH;
                    end
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        // Cancel wins over any transfer or check result this cycle.
        if (abort && (state_q != S_IDLE)) begin
            state_d    = S_IDLE;
            rom_addr_d = rom_addr_q;
            last_d     = last_q;
            rom_end_d  = rom_end_q;
            valid_d    = 1'b0;
            alast_d    = 1'b0;
            err_d      = 1'b0;
        end
    end

    always_ff @(posedge clk_1KHz or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            ram_addr_q <= '0;
            seq_q      <= '0;
            rom_addr_q <= '0;
            last_q     <= '0;
            valid_q    <= 1'b0;
            alast_q    <= 1'b0;
            rom_end_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ram_addr_q <= ram_addr_d;
            seq_q      <= seq_d;
            rom_addr_q <= rom_addr_d;
            last_q     <= last_d;
            valid_q    <= valid_d;
            alast_q    <= alast_d;
            rom_end_q  <= rom_end_d;
            err_q      <= err_d;
        end
    end

    assign ram_addr   = ram_addr_q;
    assign rom_addr   = rom_addr_q;
    assign addr_valid = valid_q;
    assign addr_last  = alast_q;
    assign rom_end    = rom_end_q;
    assign err        = err_q;
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_FINISH);

endmodule

// File: tb/tb_taglist_seq_player.sv
// Directed testbench for taglist_seq_player with a behavioural
// synchronous taglist RAM.
module tb_taglist_seq_player;

    logic        clk_1KHz = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [6:0]  seq_req = '0;
    logic        abort = 1'b0;
    logic [6:0]  ram_addr;
    logic [31:0] ram_rdata = '0;
    logic [9:0]  rom_addr;
    logic        addr_valid;
    logic        addr_ready = 1'b1;
    logic        addr_last;
    logic        rom_end;
    logic        busy;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:127];

    taglist_seq_player dut (
        .clk_1KHz   (clk_1KHz),
        .reset      (reset),
        .start      (start),
        .seq_req    (seq_req),
        .abort      (abort),
        .ram_addr   (ram_addr),
        .ram_rdata  (ram_rdata),
        .rom_addr   (rom_addr),
        .addr_valid (addr_valid),
        .addr_ready (addr_ready),
        .addr_last  (addr_last),
        .rom_end    (rom_end),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk_1KHz = ~clk_1KHz;

    always @(posedge clk_1KHz) ram_rdata <= mem[ram_addr];

    function automatic logic [31:0] ent(input logic [3:0] tag,
                                        input logic [6:0] s,
                                        input logic [9:0] f,
                                        input logic [9:0] l,
                                        input logic b0);
        return {tag, s, f, l, b0};
    endfunction

    task automatic cyc();
        @(posedge clk_1KHz);
        #1;
    endtask

    task automatic wait_valid(input string nm);
        int budget = 8;
        while (!addr_valid && budget > 0) begin
            cyc();
            budget--;
        end
        checks++;
        if (addr_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s wait_valid: addr_valid=%b required 1 within 8 cycles",
                     nm, addr_valid);
        end
    endtask

    // mode 0: ready always 1; mode 1: ready pattern 1,0,0 repeating
    task automatic run_seq(input string nm, input logic [6:0] s,
                           input logic [9:0] f, input logic [9:0] l,
                           input logic re, input int mode,
                           input bit hold_start);
        int exp_a = f;
        int n = 0;
        int k = 0;
        int total = int'(l) - int'(f) + 1;
        int guard = 4000;
        addr_ready = 1'b1;
        start = 1'b1;
        seq_req = s;
        cyc();
        if (hold_start) seq_req = 7'd2;
        else start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL %s busy_after_start: got %b required 1", nm, busy);
        end
        wait_valid(nm);
        while (n < total && guard > 0) begin
            addr_ready = (mode == 0) ? 1'b1 : ((k % 3) == 0);
            checks++;
            if (addr_valid !== 1'b1) begin
                errors++;
                $display("FAIL %s valid[%0d]: got %b required 1", nm, n, addr_valid);
            end
            checks++;
            if (rom_addr !== exp_a[9:0]) begin
                errors++;
                $display("FAIL %s rom_addr[%0d]: got %h required %h",
                         nm, n, rom_addr, exp_a[9:0]);
            end
            checks++;
            if (addr_last !== (exp_a == int'(l))) begin
                errors++;
                $display("FAIL %s addr_last[%0d]: got %b required %b",
                         nm, n, addr_last, (exp_a == int'(l)));
            end
            checks++;
            if (rom_end !== re) begin
                errors++;
                $display("FAIL %s rom_end[%0d]: got %b required %b", nm, n, rom_end, re);
            end
            if (addr_ready) begin
                n++;
                exp_a++;
            end
            k++;
            guard--;
            cyc();
        end
        addr_ready = 1'b1;
        checks++;
        if (n != total) begin
            errors++;
            $display("FAIL %s transfers: got %0d required %0d", nm, n, total);
        end
        checks++;
        if ({done, addr_valid, busy, rom_end} !== {1'b1, 1'b0, 1'b1, re}) begin
            errors++;
            $display("FAIL %s finish: done/valid/busy/rom_end got %b%b%b%b required 101%b",
                     nm, done, addr_valid, busy, rom_end, re);
        end
        cyc();
        start = 1'b0;
        checks++;
        if ({done, busy} !== 2'b00) begin
            errors++;
            $display("FAIL %s idle_after: done/busy got %b%b required 00", nm, done, busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        cyc();
        cyc();
        checks++;
        if ({ram_addr, rom_addr, addr_valid, addr_last, rom_end, busy, done, err} !== '0) begin
            errors++;
            $display("FAIL reset_state: outputs got %h/%h/%b%b%b%b%b%b required all 0",
                     ram_addr, rom_addr, addr_valid, addr_last, rom_end, busy, done, err);
        end
        #2 reset = 1'b1;
        cyc();
    endtask

    task automatic test_basic();
        mem[5] = ent(4'h0, 7'd5, 10'h010, 10'h013, 1'b0);
        run_seq("basic", 7'd5, 10'h010, 10'h013, 1'b0, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        run_seq("backpressure", 7'd5, 10'h010, 10'h013, 1'b0, 1, 1'b1);
    endtask

    task automatic test_single();
        mem[2] = ent(4'h0, 7'd2, 10'h3FF, 10'h3FF, 1'b1);
        run_seq("single", 7'd2, 10'h3FF, 10'h3FF, 1'b1, 0, 1'b0);
    endtask

    task automatic test_full_range();
        mem[9] = ent(4'h0, 7'd9, 10'h000, 10'h3FF, 1'b0);
        run_seq("full", 7'd9, 10'h000, 10'h3FF, 1'b0, 0, 1'b0);
    endtask

    task automatic test_err(input string nm, input logic [31:0] e);
        mem[7] = e;
        start = 1'b1;
        seq_req = 7'd7;
        cyc();
        start = 1'b0;
        cyc();
        checks++;
        if ({busy, addr_valid, err} !== 3'b100) begin
            errors++;
            $display("FAIL %s check_cycle: busy/valid/err got %b%b%b required 100",
                     nm, busy, addr_valid, err);
        end
        cyc();
        checks++;
        if ({err, busy, addr_valid} !== 3'b100) begin
            errors++;
            $display("FAIL %s err_pulse: err/busy/valid got %b%b%b required 100",
                     nm, err, busy, addr_valid);
        end
        cyc();
        checks++;
        if ({err, busy, addr_valid} !== 3'b000) begin
            errors++;
            $display("FAIL %s err_clear: err/busy/valid got %b%b%b required 000",
                     nm, err, busy, addr_valid);
        end
    endtask

    task automatic test_abort();
        mem[3] = ent(4'h0, 7'd3, 10'h100, 10'h105, 1'b1);
        addr_ready = 1'b1;
        start = 1'b1;
        seq_req = 7'd3;
        cyc();
        start = 1'b0;
        wait_valid("abort");
        cyc();
        checks++;
        if (rom_addr !== 10'h101) begin
            errors++;
            $display("FAIL abort_second: rom_addr got %h required 101", rom_addr);
        end
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        checks++;
        if ({addr_valid, addr_last, busy, done, err, rom_end} !== 6'b000001) begin
            errors++;
            $display("FAIL abort_after: valid/last/busy/done/err/rom_end got %b%b%b%b%b%b required 000001",
                     addr_valid, addr_last, busy, done, err, rom_end);
        end
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++;
            if ({done, busy, addr_valid} !== 3'b000) begin
                errors++;
                $display("FAIL abort_quiet[%0d]: done/busy/valid got %b%b%b required 000",
                         i, done, busy, addr_valid);
            end
        end
        run_seq("after_abort", 7'd3, 10'h100, 10'h105, 1'b1, 0, 1'b0);
    endtask

    task automatic test_reset_midstream();
        addr_ready = 1'b1;
        start = 1'b1;
        seq_req = 7'd3;
        cyc();
        start = 1'b0;
        wait_valid("midreset");
        cyc();
        cyc();
        checks++;
        if ({rom_addr, rom_end} !== {10'h102, 1'b1}) begin
            errors++;
            $display("FAIL midreset_pre: rom_addr/rom_end got %h/%b required 102/1",
                     rom_addr, rom_end);
        end
        #3 reset = 1'b0;
        #1;
        checks++;
        if ({ram_addr, rom_addr, addr_valid, addr_last, rom_end, busy, done, err} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: got %h/%h/%b%b%b%b%b%b required all 0",
                     ram_addr, rom_addr, addr_valid, addr_last, rom_end, busy, done, err);
        end
        #2 reset = 1'b1;
        cyc();
        run_seq("after_reset", 7'd3, 10'h100, 10'h105, 1'b1, 0, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = '0;
        test_reset();
        test_basic();
        test_backpressure();
        test_single();
        test_err("err_seq", ent(4'h0, 7'd6, 10'h010, 10'h013, 1'b0));
        test_err("err_order", ent(4'h0, 7'd7, 10'h020, 10'h01F, 1'b0));
        test_err("err_tag", ent(4'h1, 7'd7, 10'h010, 10'h013, 1'b0));
        test_abort();
        test_reset_midstream();
        test_full_range();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
